u111_dynamic_sizer: RTL

U111_DYNAMIC_SIZER -- requirements
Module: u111_dynamic_sizer

---
 rtl/u111_dynamic_sizer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/u111_dynamic_sizer.sv
// 68040-to-Amiga dynamic bus sizer: splits one CPU transfer into 1, 2 or 4 port beats
// on a 32/16/8-bit target, steering byte lanes and reporting completion or bus error.
module u111_dynamic_sizer #(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned LINE_TBI = 1
) (
    input  logic        CLK40,
    input  logic        RESETn,
    input  logic        TS_CPUn,
    input  logic        RnW,
    input  logic [1:0]  SIZ,
    input  logic [1:0]  A_040,
    input  logic [1:0]  PORTSIZE,
    input  logic        TACKn,
    input  logic        TEAn,
    input  logic [31:0] D_040_IN,
    input  logic [31:0] D_AMIGA_IN,
    output logic        TSn,
    output logic [1:0]  A_AMIGA,
    output logic        TAn,
    output logic        TEA_CPUn,
    output logic        TBI_CPUn,
    output logic        CPU_CYCLE,
    output logic [31:0] D_040_OUT,
    output logic        D_040_OE,
    output logic [31:0] D_AMIGA_OUT,
    output logic        D_AMIGA_OE
);

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, NEXT, ACK} state_t;

    state_t        state_q, state_d;
    logic          rnw_q, rnw_d;
    logic          line_q, line_d;
    logic          err_q, err_d;
    logic [1:0]    ps_q, ps_d;       // 0: 32-bit, 1: 16-bit, 2: 8-bit
    logic [1:0]    addr_q, addr_d;
    logic [1:0]    beat_q, beat_d;   // beats remaining after the current one
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    ps_in;
    logic [1:0]    step;

    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            rnw_q   <= 1'b0;
            line_q  <= 1'b0;
            err_q   <= 1'b0;
            ps_q    <= '0;
            addr_q  <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rnw_q   <= rnw_d;
            line_q  <= line_d;
            err_q   <= err_d;
            ps_q    <= ps_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rnw_d   = rnw_q;
        line_d  = line_q;
        err_d   = err_q;
        ps_d    = ps_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ps_in   = (PORTSIZE == 2'b11) ? 2'b00 : PORTSIZE;
        step    = (ps_q == 2'd1) ? 2'd2 : ((ps_q == 2'd2) ? 2'd1 : 2'd0);

        case (state_q)
            IDLE: begin
                if (!TS_CPUn) begin
                    rnw_d  = RnW;
                    line_d = (SIZ == 2'b11);
                    ps_d   = ps_in;
                    err_d  = 1'b0;
                    case (SIZ)
                        2'b01: begin
                            addr_d = A_040;
                            beat_d = 2'd0;
                        end
                        2'b10: begin
                            addr_d = {A_040[1], 1'b0};
                            beat_d = (ps_in == 2'd2) ? 2'd1 : 2'd0;
                        end
                        default: begin
                            addr_d = 2'b00;
                            beat_d = (ps_in == 2'd2) ? 2'd3 : ((ps_in == 2'd1) ? 2'd1 : 2'd0);
                        end
                    endcase
                    if (!RnW) wdata_d = D_040_IN;
                    else      rdata_d = '0;
                    state_d = START;
                end
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (!TEAn) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end else if (!TACKn) begin
                    if (rnw_q) begin
                        // Port lanes land in the CPU byte positions of the current address.
                        case (ps_q)
                            2'd1: begin
                                if (addr_q[1]) rdata_d[15:0]  = D_AMIGA_IN[31:16];
                                else           rdata_d[31:16] = D_AMIGA_IN[31:16];
                            end
                            2'd2: begin
                                case (addr_q)
                                    2'd0:    rdata_d[31:24] = D_AMIGA_IN[31:24];
                                    2'd1:    rdata_d[23:16] = D_AMIGA_IN[31:24];
                                    2'd2:    rdata_d[15:8]  = D_AMIGA_IN[31:24];
                                    default: rdata_d[7:0]   = D_AMIGA_IN[31:24];
                                endcase
                            end
                            default: rdata_d = D_AMIGA_IN;
                        endcase
                    end
                    state_d = (beat_q == 2'd0) ? ACK : NEXT;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            NEXT: begin
                addr_d  = addr_q + step;
                beat_d  = beat_q - 1'b1;
                state_d = START;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (ps_q)
            2'd1:    D_AMIGA_OUT = {(addr_q[1] ? wdata_q[15:0] : wdata_q[31:16]), 16'h0000};
            2'd2: begin
                case (addr_q)
                    2'd0:    D_AMIGA_OUT = {wdata_q[31:24], 24'h000000};
                    2'd1:    D_AMIGA_OUT = {wdata_q[23:16], 24'h000000};
                    2'd2:    D_AMIGA_OUT = {wdata_q[15:8],  24'h000000};
                    default: D_AMIGA_OUT = {wdata_q[7:0],   24'h000000};
                endcase
            end
            default: D_AMIGA_OUT = wdata_q;
        endcase
    end

    assign CPU_CYCLE  = (state_q != IDLE);
    assign TSn        = !(state_q == START);
    assign A_AMIGA    = addr_q;
    assign TAn        = !((state_q == ACK) && !err_q);
    assign TEA_CPUn   = !((state_q == ACK) && err_q);
    assign TBI_CPUn   = !((state_q == ACK) && !err_q && line_q && (LINE_TBI != 0));
    assign D_040_OUT  = rdata_q;
    assign D_040_OE   = (state_q == ACK) && rnw_q;
    assign D_AMIGA_OE = !rnw_q && ((state_q == START) || (state_q == WAIT));

endmodule
